// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_fsm
// Purpose  : Multi-cycle CPU control sequencer. It fetches an instruction,
//            decodes it into ALU operand registers, captures the ALU result,
//            and then writes the register file and advances the PC. Faulting
//            or illegal instructions park the core in a terminal HALT state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC        PC value loaded on reset
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           leaves IDLE and begins fetching at pc
//   imem_*          instruction fetch handshake (req/addr out, valid/rdata in)
//   rf_rs*_addr/data  combinational register-file read
//   alu_*  (out)    registered ALU operands, opcode and function
//   alu_*  (in)     ALU result, pc-update flag, write enable, error flag
//   rf_wr_*         register-file write port
//   pc, busy, halted  status
//   retired_cnt     WRITEBACK cycle count (only with RETIRE_COUNTER_EN)
// Build option
//   RETIRE_COUNTER_EN  adds the retired_cnt output and its counter
// ============================================================================
module cpu_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic [31:0] alu_rs1_data,
  output logic [31:0] alu_rs2_data,
  output logic [31:0] alu_imm,
  output logic [6:0]  alu_opcode,
  output logic [3:0]  alu_func,
  input  logic [31:0] alu_sonuc,
  input  logic        alu_pc_update,
  input  logic        alu_we,
  input  logic        alu_hata,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  localparam logic [6:0] c_OP_RTYPE = 7'b0000001;
  localparam logic [6:0] c_OP_IMM_S = 7'b0000011;
  localparam logic [6:0] c_OP_IMM_Z = 7'b0000111;
  localparam logic [6:0] c_OP_BRNCH = 7'b0001111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm;
  logic [6:0]  r_opcode;
  logic [3:0]  r_func;
  logic [31:0] r_sonuc;
  logic        r_pc_update;
  logic        r_we;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_legal;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[15:11];

  // Immediate decode from the latched instruction word.
  always_comb begin
    w_imm = 32'd0;
    case (w_opcode)
      c_OP_IMM_S: w_imm = {{21{r_instr[31]}}, r_instr[31:21]};
      c_OP_IMM_Z: w_imm = {16'd0, r_instr[31:16]};
      c_OP_BRNCH: w_imm = {{21{r_instr[31]}}, r_instr[31:26], r_instr[15:11]};
      default:    w_imm = 32'd0;
    endcase
  end

  // Legality is judged on the operand registers that the ALU is working on,
  // so the decision lines up with the EXECUTE cycle.
  always_comb begin
    w_legal = 1'b0;
    case (r_opcode)
      c_OP_RTYPE: begin
        case (r_func)
          4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13: w_legal = 1'b1;
          default:                                         w_legal = 1'b0;
        endcase
      end
      c_OP_IMM_S, c_OP_IMM_Z, c_OP_BRNCH: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    rf_wr_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy        = 1'b1;
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        busy = 1'b1;
        if (alu_hata || !w_legal) w_state_nxt = S_HALT;
        else                      w_state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        busy        = 1'b1;
        rf_wr_en    = r_we && (w_rd != 5'd0);
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_imm       <= 32'd0;
      r_opcode    <= 7'd0;
      r_func      <= 4'd0;
      r_sonuc     <= 32'd0;
      r_pc_update <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_FETCH: begin
          if (imem_valid) r_instr <= imem_rdata;
        end
        S_DECODE: begin
          r_rs1_data <= rf_rs1_data;
          r_rs2_data <= rf_rs2_data;
          r_imm      <= w_imm;
          r_opcode   <= w_opcode;
          r_func     <= r_instr[10:7];
        end
        S_EXECUTE: begin
          r_sonuc     <= alu_sonuc;
          r_pc_update <= alu_pc_update;
          r_we        <= alu_we;
        end
        S_WRITEBACK: begin
          // Relative jump by the ALU result, or sequential advance; both wrap.
          r_pc <= r_pc_update ? (r_pc + r_sonuc) : (r_pc + 32'd4);
        end
        default: ;
      endcase
    end
  end

`ifdef RETIRE_COUNTER_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt <= 32'd0;
    end else if (r_state == S_WRITEBACK) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
`endif

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign rf_rs1_addr  = r_instr[20:16];
  assign rf_rs2_addr  = r_instr[25:21];
  assign alu_rs1_data = r_rs1_data;
  assign alu_rs2_data = r_rs2_data;
  assign alu_imm      = r_imm;
  assign alu_opcode   = r_opcode;
  assign alu_func     = r_func;
  assign rf_wr_addr   = w_rd;
  assign rf_wr_data   = r_sonuc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_fsm
// Purpose  : Self-checking bench for cpu_ctrl_fsm. Provides a register file,
//            an ALU and an instruction memory around the controller, runs a
//            table of directed instructions, hand-written halt/reset corner
//            cases and a randomized instruction stream against a reference
//            model of the architectural behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [31:0] alu_rs1_data, alu_rs2_data, alu_imm;
  logic [6:0]  alu_opcode;
  logic [3:0]  alu_func;
  logic [31:0] alu_sonuc;
  logic        alu_pc_update, alu_we, alu_hata;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pc;
  logic        busy, halted;
`ifdef RETIRE_COUNTER_EN
  logic [31:0] retired_cnt;
`endif

  cpu_ctrl_fsm #(.RESET_PC(c_RESET_PC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
    .alu_imm(alu_imm), .alu_opcode(alu_opcode), .alu_func(alu_func),
    .alu_sonuc(alu_sonuc), .alu_pc_update(alu_pc_update),
    .alu_we(alu_we), .alu_hata(alu_hata),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef RETIRE_COUNTER_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- environment: register file and ALU ----------------
  logic [31:0] regs [32];
  logic        tb_hata = 1'b0;

  typedef struct packed {
    logic [31:0] sonuc;
    logic        pcu;
    logic        we;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [6:0] op, input logic [3:0] fn,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm);
    alu_res_t r;
    r = '0;
    case (op)
      7'h03: begin r.sonuc = a + imm; r.we = 1'b1; end
      7'h07: begin r.sonuc = imm;     r.we = 1'b1; end
      7'h0F: begin r.pcu = (fn == 4'd0) ? (a == b) : (a != b); r.sonuc = imm; end
      7'h01: begin
        r.we = 1'b1;
        case (fn)
          4'd0:    r.sonuc = a + b;
          4'd1:    r.sonuc = a - b;
          4'd4:    r.sonuc = a & b;
          4'd5:    r.sonuc = a | b;
          4'd6:    r.sonuc = a ^ b;
          4'd7:    r.sonuc = a << b[4:0];
          4'd8:    r.sonuc = {31'd0, ($signed(a) < $signed(b))};
          4'd13:   r.sonuc = $signed(a) >>> b[4:0];
          default: r.sonuc = 32'd0;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  alu_res_t env_res;
  assign rf_rs1_data   = regs[rf_rs1_addr];
  assign rf_rs2_data   = regs[rf_rs2_addr];
  assign env_res       = alu_eval(alu_opcode, alu_func, alu_rs1_data, alu_rs2_data, alu_imm);
  assign alu_sonuc     = env_res.sonuc;
  assign alu_pc_update = env_res.pcu;
  assign alu_we        = env_res.we;
  assign alu_hata      = tb_hata;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [3:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {6'd0, rs2, rs1, rd, fn, 7'h01};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [10:0] imm);
    return {imm, rs1, rd, 4'd0, 7'h03};
  endfunction
  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [15:0] imm);
    return {imm, rd, 4'd0, 7'h07};
  endfunction
  function automatic logic [31:0] enc_b(input logic [3:0] fn, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [10:0] imm);
    return {imm[10:5], rs2, rs1, imm[4:0], fn, 7'h0F};
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    case (i[6:0])
      7'h03:   return {{21{i[31]}}, i[31:21]};
      7'h07:   return {16'd0, i[31:16]};
      7'h0F:   return {{21{i[31]}}, i[31:26], i[15:11]};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- checking ----------------
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural reference: what one instruction must do given the current
  // register contents and pc.
  task automatic model_expect(input logic [31:0] instr, input logic hata,
                              output logic e_halt, output logic e_we,
                              output logic [4:0] e_addr, output logic [31:0] e_data,
                              output logic [31:0] e_pc);
    logic [6:0] op;
    logic [3:0] fn;
    logic       legal;
    alu_res_t   res;
    op     = instr[6:0];
    fn     = instr[10:7];
    res    = alu_eval(op, fn, regs[instr[20:16]], regs[instr[25:21]], exp_imm(instr));
    legal  = (op inside {7'h01, 7'h03, 7'h07, 7'h0F}) &&
             (op != 7'h01 || fn inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13});
    e_halt = hata || !legal;
    e_addr = instr[15:11];
    e_we   = res.we && (e_addr != 5'd0);
    e_data = res.sonuc;
    e_pc   = res.pcu ? m_pc + res.sonuc : m_pc + 32'd4;
  endtask

  // Entered at the negedge of the first FETCH cycle. Serves the fetch after
  // wt wait cycles, then steps DECODE, EXECUTE and WRITEBACK/HALT.
  task automatic do_instr(input logic [31:0] instr, input int wt, input logic hata,
                          input logic e_halt, input logic e_we, input logic [4:0] e_addr,
                          input logic [31:0] e_data, input logic [31:0] e_pc);
    logic [31:0] a, b;
    a = regs[instr[20:16]];
    b = regs[instr[25:21]];
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_busy", busy, 1);
    for (int i = 0; i < wt; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, m_pc);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    tb_hata    = hata;
    @(negedge clk);  // DECODE
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    check("dec_req", imem_req, 0);
    check("dec_wr", rf_wr_en, 0);
    check("dec_rs1_addr", rf_rs1_addr, instr[20:16]);
    check("dec_rs2_addr", rf_rs2_addr, instr[25:21]);
    @(negedge clk);  // EXECUTE
    check("ex_opcode", alu_opcode, instr[6:0]);
    check("ex_func", alu_func, instr[10:7]);
    check("ex_imm", alu_imm, exp_imm(instr));
    check("ex_rs1", alu_rs1_data, a);
    check("ex_rs2", alu_rs2_data, b);
    check("ex_wr", rf_wr_en, 0);
    @(negedge clk);  // WRITEBACK or HALT
    if (e_halt) begin
      check("halt_halted", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_pc", pc, m_pc);
      check("halt_req", imem_req, 0);
      check("halt_wr", rf_wr_en, 0);
    end else begin
      check("wb_halted", halted, 0);
      check("wb_pc_hold", pc, m_pc);
      check("wb_wr_en", rf_wr_en, e_we);
      if (e_we) begin
        check("wb_wr_addr", rf_wr_addr, e_addr);
        check("wb_wr_data", rf_wr_data, e_data);
        regs[e_addr] = e_data;
      end
      exp_retired = exp_retired + 32'd1;
      @(negedge clk);  // next FETCH
      check("next_pc", pc, e_pc);
      check("next_req", imem_req, 1);
`ifdef RETIRE_COUNTER_EN
      check("retired_cnt", retired_cnt, exp_retired);
`endif
      m_pc = e_pc;
    end
    imem_valid = 1'b0;
    tb_hata    = 1'b0;
  endtask

  task automatic run_model(input logic [31:0] instr, input int wt, input logic hata,
                           output logic e_halt);
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_pc;
    model_expect(instr, hata, e_halt, e_we, e_addr, e_data, e_pc);
    do_instr(instr, wt, hata, e_halt, e_we, e_addr, e_data, e_pc);
  endtask

  // Asserts reset at the current time and checks its immediate effect.
  task automatic do_reset();
    start      = 1'b0;
    imem_valid = 1'b0;
    tb_hata    = 1'b0;
    rst        = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, c_RESET_PC);
    check("rst_pc", pc, c_RESET_PC);
    check("rst_wr", rf_wr_en, 0);
    check("rst_opnd", alu_rs1_data | alu_rs2_data | alu_imm, 0);
    check("rst_opc", {alu_opcode, alu_func}, 0);
`ifdef RETIRE_COUNTER_EN
    check("rst_retired", retired_cnt, 0);
`endif
    @(negedge clk);
    check("rst_hold_wr", rf_wr_en, 0);
    rst         = 1'b0;
    m_pc        = c_RESET_PC;
    exp_retired = 32'd0;
  endtask

  task automatic start_cpu();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3)      r[6:0] = 7'h01;
    else if (k <= 5) r[6:0] = 7'h03;
    else if (k == 6) r[6:0] = 7'h07;
    else if (k <= 8) begin
      logic [10:0] bi;
      bi = 11'((int'($urandom_range(0, 16)) - 8) * 4);
      r  = enc_b(4'(r[7]), r[20:16], r[25:21], bi);
    end
    return r;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] instr;
    int          wt;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic h;
    tbl[0]  = '{enc_i(5'd3, 5'd0, 11'd5),        0, 1'b1, 5'd3,  32'd5,          32'd4};
    tbl[1]  = '{enc_i(5'd4, 5'd3, 11'h7FE),      3, 1'b1, 5'd4,  32'd3,          32'd8};
    tbl[2]  = '{enc_u(5'd5, 16'hABCD),           0, 1'b1, 5'd5,  32'h0000_ABCD,  32'd12};
    tbl[3]  = '{enc_r(4'd0, 5'd6, 5'd3, 5'd4),   1, 1'b1, 5'd6,  32'd8,          32'd16};
    tbl[4]  = '{enc_b(4'd0, 5'd3, 5'd4, 11'h7F8), 0, 1'b0, 5'd0, 32'd0,          32'd20};
    tbl[5]  = '{enc_i(5'd7, 5'd0, 11'h7FC),      2, 1'b1, 5'd7,  32'hFFFF_FFFC,  32'd24};
    tbl[6]  = '{enc_r(4'd1, 5'd8, 5'd3, 5'd4),   0, 1'b1, 5'd8,  32'd2,          32'd28};
    tbl[7]  = '{enc_r(4'd0, 5'd0, 5'd3, 5'd4),   0, 1'b0, 5'd0,  32'd0,          32'd32};
    tbl[8]  = '{enc_b(4'd0, 5'd3, 5'd3, 11'h7F0), 0, 1'b0, 5'd0, 32'd0,          32'd16};
    tbl[9]  = '{enc_b(4'd0, 5'd4, 5'd4, 11'h7F8), 0, 1'b0, 5'd0, 32'd0,          32'd8};
    tbl[10] = '{enc_r(4'd6, 5'd9, 5'd5, 5'd3),   0, 1'b1, 5'd9,  32'h0000_ABC8,  32'd12};
    tbl[11] = '{enc_u(5'd10, 16'h8000),          0, 1'b1, 5'd10, 32'h0000_8000,  32'd16};
    tbl[12] = '{enc_i(5'd11, 5'd0, 11'h400),     0, 1'b1, 5'd11, 32'hFFFF_FC00,  32'd20};
    tbl[13] = '{enc_b(4'd0, 5'd0, 5'd0, 11'h7EC), 0, 1'b0, 5'd0, 32'd0,          32'd0};
    tbl[14] = '{enc_b(4'd0, 5'd0, 5'd0, 11'h7FC), 0, 1'b0, 5'd0, 32'd0,          32'hFFFF_FFFC};
    tbl[15] = '{enc_i(5'd1, 5'd0, 11'd1),        0, 1'b1, 5'd1,  32'd1,          32'd0};
    tbl[16] = '{enc_r(4'd13, 5'd12, 5'd7, 5'd1), 0, 1'b1, 5'd12, 32'hFFFF_FFFE,  32'd4};
    tbl[17] = '{enc_r(4'd8, 5'd13, 5'd7, 5'd3),  0, 1'b1, 5'd13, 32'd1,          32'd8};

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    m_pc        = c_RESET_PC;
    exp_retired = 32'd0;

    @(negedge clk);
    do_reset();

    // Fetch responses and stray valids are ignored while idle.
    imem_valid = 1'b1;
    imem_rdata = enc_i(5'd2, 5'd0, 11'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_req", imem_req, 0);
    end
    imem_valid = 1'b0;

    // Directed table.
    start_cpu();
    for (int i = 0; i < 18; i++)
      do_instr(tbl[i].instr, tbl[i].wt, 1'b0, 1'b0, tbl[i].e_we, tbl[i].e_addr,
               tbl[i].e_data, tbl[i].e_pc);

    // Illegal R-type function at pc=12 halts with pc frozen; start and
    // fetch responses have no effect afterwards.
    do_reset();
    start_cpu();
    for (int i = 0; i < 3; i++) run_model(enc_i(5'd1, 5'd0, 11'd1), 0, 1'b0, h);
    run_model(enc_r(4'b0010, 5'd1, 5'd2, 5'd3), 0, 1'b0, h);
    check("halt_expected", h, 1);
    for (int i = 0; i < 4; i++) begin
      start      = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = enc_i(5'd1, 5'd0, 11'd1);
      @(negedge clk);
      check("halt_hold_halted", halted, 1);
      check("halt_hold_busy", busy, 0);
      check("halt_hold_req", imem_req, 0);
      check("halt_hold_pc", pc, 32'd12);
      check("halt_hold_wr", rf_wr_en, 0);
    end
    start      = 1'b0;
    imem_valid = 1'b0;

    // ALU error on a legal instruction, then an unknown opcode.
    do_reset();
    start_cpu();
    run_model(enc_i(5'd2, 5'd0, 11'd7), 1, 1'b1, h);
    check("hata_halt", halted, 1);
    do_reset();
    start_cpu();
    run_model(enc_i(5'd2, 5'd0, 11'd7), 0, 1'b0, h);
    run_model({25'h0, 7'b0100011}, 0, 1'b0, h);
    check("badop_pc", pc, 32'd4);

    // Reset during EXECUTE.
    do_reset();
    start_cpu();
    imem_valid = 1'b1;
    imem_rdata = enc_i(5'd2, 5'd0, 11'd7);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    do_reset();
    start_cpu();
    run_model(enc_i(5'd2, 5'd0, 11'd7), 0, 1'b0, h);

    // Reset during a fetch wait and during a writeback.
    do_reset();
    start_cpu();
    @(negedge clk);
    check("wait_before_rst", imem_req, 1);
    do_reset();
    start_cpu();
    imem_valid = 1'b1;
    imem_rdata = enc_i(5'd2, 5'd0, 11'd7);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wb_before_rst", rf_wr_en, 1);
    do_reset();

    // Randomized instruction stream against the reference model.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    start_cpu();
    for (int n = 0; n < 120; n++) begin
      run_model(rand_instr(), $urandom_range(0, 3), ($urandom_range(0, 19) == 0), h);
      if (h) begin
        do_reset();
        start_cpu();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching at pc.
REQ-005 SHALL have ports imem_req output 1, imem_addr output 32, imem_valid input 1, imem_rdata input 32: instruction fetch handshake.
REQ-006 SHALL have ports rf_rs1_addr output 5, rf_rs2_addr output 5, rf_rs1_data input 32, rf_rs2_data input 32: combinational register-file read.
REQ-007 SHALL have ports alu_rs1_data output 32, alu_rs2_data output 32, alu_imm output 32, alu_opcode output 7, alu_func output 4: ALU operands.
REQ-008 SHALL have ports alu_sonuc input 32, alu_pc_update input 1, alu_we input 1, alu_hata input 1: ALU results.
REQ-009 SHALL have ports rf_wr_en output 1, rf_wr_addr output 5, rf_wr_data output 32: register-file write.
REQ-010 SHALL have ports pc output 32, busy output 1, halted output 1: status.

Function
REQ-011 Instruction fields SHALL be opcode=[6:0], func=[10:7], rd=[15:11], rs1=[20:16], rs2=[25:21].
REQ-012 alu_imm SHALL be: opcode 7'b0000011 -> sign-extend [31:21]; 7'b0000111 -> zero-extend [31:16]; 7'b0001111 -> sign-extend {[31:26],[15:11]}; else 0.
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-014 IDLE: start=1 -> FETCH; start ignored in all other states.
REQ-015 FETCH: imem_req=1, imem_addr=pc held stable until imem_valid=1; on imem_valid instruction latched -> DECODE.
REQ-016 imem_valid outside FETCH SHALL be ignored.
REQ-017 DECODE (1 cycle): rf read addresses driven from latched rs1/rs2, rf_rs*_data, opcode, func and imm registered into ALU operand registers -> EXECUTE.
REQ-018 EXECUTE (1 cycle): alu_sonuc, alu_pc_update, alu_we registered; if alu_hata=1, opcode not one of the four legal codes, or R-type (7'b0000001) func not in {0,1,4,5,6,7,8,13} -> HALT, else -> WRITEBACK.
REQ-019 WRITEBACK (1 cycle): rf_wr_en=1 iff captured we=1 and rd!=0; rf_wr_addr=rd, rf_wr_data=captured sonuc; -> FETCH.
REQ-020 WRITEBACK PC: captured pc_update=1 -> pc <= pc + sonuc; else pc <= pc + 4; modulo 2^32 wrap, no overflow flag.
REQ-021 rf_wr_en SHALL be 0 in every state except WRITEBACK.
REQ-022 Minimum latency SHALL be 4 cycles per instruction (imem_valid in first FETCH cycle); each imem wait cycle adds 1.
REQ-023 busy SHALL be 1 in FETCH, DECODE, EXECUTE, WRITEBACK; 0 in IDLE and HALT.
REQ-024 HALT SHALL be terminal: halted=1, no fetch, no writes, pc frozen at faulting instruction, until rst.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, rf_wr_en=0, busy=0, halted=0, all operand/result registers 0.
REQ-026 Reset mid-operation SHALL abandon any pending fetch or writeback with no register-file write.

Configuration
REQ-027 With RETIRE_COUNTER_EN defined, SHALL add output retired_cnt (32) counting WRITEBACK cycles, reset to 0, wrapping at 2^32.
REQ-028 Without RETIRE_COUNTER_EN, port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 rst, start, zero-wait memory, instr addi rd=3 rs1=0 imm=5 with ALU model -> rf write r3=5 in cycle 4, pc=4.
REQ-030 imem_valid delayed 3 cycles -> imem_addr stable, imem_req held, instruction completes in 7 cycles.
REQ-031 beq with equal operands, imm=-8, pc=16 -> no rf write, pc=8; unequal -> pc=20.
REQ-032 R-type func=4'b0010 at pc=12 -> HALT, halted=1, busy=0, pc=12, no further imem_req.
REQ-033 rst asserted during EXECUTE -> next edge-independent: state IDLE, rf_wr_en=0, pc=RESET_PC.
REQ-034 add with rd=0 -> rf_wr_en stays 0; RETIRE_COUNTER_EN build: retired_cnt increments by 1.
